// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised wrap/saturate up/down counter with load, clear and boundary flags
module param_updown_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = '1,
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             tc,
    output logic             wrapped,
    output logic             ovf
);
    // one extra bit so sums and wrap corrections never truncate
    localparam logic [WIDTH:0] MAX = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] STP = {1'b0, STEP};
    localparam logic [WIDTH:0] MOD = {1'b0, MAX_VAL} + 1'b1;
    localparam logic [WIDTH:0] RST = {1'b0, RESET_VAL};
    logic [WIDTH:0] cnt, lv, up_val, dn_val, nxt;
    logic up_hit, dn_hit;
    always_comb begin
        cnt = {1'b0, count};
        lv = ({1'b0, load_val} > MAX) ? MAX : {1'b0, load_val};
        up_hit = cnt > MAX - STP;
        dn_hit = cnt < STP;
        up_val = up_hit ? (SATURATE ? MAX : cnt + STP - MOD) : cnt + STP;
        dn_val = dn_hit ? (SATURATE ? '0 : cnt + MOD - STP) : cnt - STP;
        nxt = clr ? RST : load ? lv : en ? (dir ? up_val : dn_val) : cnt;
        tc = en & ~clr & ~load & (dir ? up_hit : dn_hit);
    end
    assign count_next = WIDTH'(nxt);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RESET_VAL;
            wrapped <= 1'b0;
            ovf <= 1'b0;
        end else begin
            count <= count_next;
            wrapped <= tc;
            ovf <= ~clr & (ovf | tc);
        end
    end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: table vectors plus random traffic against an arithmetic model on four configurations
module tb_param_updown_counter;
    typedef struct {
        bit clr;
        bit load;
        logic [7:0] lv;
        bit en;
        bit dir;
        int idx;
        int cnt;
        bit tc;
        bit wr;
        bit ovf;
    } vec_t;
    logic clk = 1'b0, rst = 1'b0, clr = 1'b0, load = 1'b0, en = 1'b0, dir = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] cnt [4];
    logic [7:0] cnt_nx [4];
    logic tc [4];
    logic wr [4];
    logic ovf [4];
    int maxv [4] = '{255, 9, 200, 100};
    int stp [4] = '{1, 3, 7, 1};
    bit sat [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int mc [4], mov [4], mwr [4];
    int n_chk = 0, n_fail = 0;
    vec_t tbl [$];
    always #5 clk = ~clk;
    param_updown_counter u_a (.clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .dir(dir),
        .count(cnt[0]), .count_next(cnt_nx[0]), .tc(tc[0]), .wrapped(wr[0]), .ovf(ovf[0]));
    param_updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .STEP(8'd3)) u_b (.clk(clk), .rst(rst), .clr(clr), .load(load),
        .load_val(load_val), .en(en), .dir(dir), .count(cnt[1]), .count_next(cnt_nx[1]), .tc(tc[1]), .wrapped(wr[1]), .ovf(ovf[1]));
    param_updown_counter #(.WIDTH(8), .MAX_VAL(8'd200), .STEP(8'd7), .SATURATE(1'b1)) u_c (.clk(clk), .rst(rst), .clr(clr),
        .load(load), .load_val(load_val), .en(en), .dir(dir), .count(cnt[2]), .count_next(cnt_nx[2]), .tc(tc[2]), .wrapped(wr[2]),
        .ovf(ovf[2]));
    param_updown_counter #(.WIDTH(8), .MAX_VAL(8'd100)) u_d (.clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .count(cnt[3]), .count_next(cnt_nx[3]), .tc(tc[3]), .wrapped(wr[3]), .ovf(ovf[3]));
    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // candidate value of an enabled step, before any range handling
    function automatic int raw_step(int i);
        return dir ? mc[i] + stp[i] : mc[i] - stp[i];
    endfunction
    function automatic int ref_tc(int i);
        int s = raw_step(i);
        return (en && !clr && !load && (s < 0 || s > maxv[i])) ? 1 : 0;
    endfunction
    function automatic int ref_next(int i);
        int s = raw_step(i);
        int m = maxv[i] + 1;
        if (clr) return 0;
        if (load) return (int'(load_val) > maxv[i]) ? maxv[i] : int'(load_val);
        if (!en) return mc[i];
        if (s >= 0 && s <= maxv[i]) return s;
        if (sat[i]) return dir ? maxv[i] : 0;
        return (s + m) % m;
    endfunction
    task automatic tick(vec_t v, bit use_tbl);
        int t;
        clr = v.clr; load = v.load; load_val = v.lv; en = v.en; dir = v.dir;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tc[%0d]", i), int'(tc[i]), ref_tc(i));
            chk($sformatf("count_next[%0d]", i), int'(cnt_nx[i]), ref_next(i));
        end
        if (use_tbl) chk($sformatf("tbl_tc[%0d]", v.idx), int'(tc[v.idx]), int'(v.tc));
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            t = ref_tc(i);
            mc[i] = ref_next(i);
            mov[i] = clr ? 0 : (mov[i] | t);
            mwr[i] = t;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("count[%0d]", i), int'(cnt[i]), mc[i]);
            chk($sformatf("wrapped[%0d]", i), int'(wr[i]), mwr[i]);
            chk($sformatf("ovf[%0d]", i), int'(ovf[i]), mov[i]);
        end
        if (use_tbl) begin
            chk($sformatf("tbl_count[%0d]", v.idx), int'(cnt[v.idx]), v.cnt);
            chk($sformatf("tbl_wrapped[%0d]", v.idx), int'(wr[v.idx]), int'(v.wr));
            chk($sformatf("tbl_ovf[%0d]", v.idx), int'(ovf[v.idx]), int'(v.ovf));
        end
    endtask
    initial begin
        vec_t rv;
        tbl = '{
            '{0, 1, 8'hFE, 1, 1, 0, 'hFE, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 0, 'hFF, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 0, 'h00, 1, 1, 1},
            '{0, 0, 8'h00, 0, 1, 0, 'h00, 0, 0, 1},
            '{1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 1, 3, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 1, 6, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 1, 9, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 1, 2, 1, 1, 1},
            '{0, 0, 8'h00, 1, 1, 1, 5, 0, 0, 1},
            '{0, 1, 8'h01, 0, 0, 1, 1, 0, 0, 1},
            '{0, 0, 8'h00, 1, 0, 1, 8, 1, 1, 1},
            '{0, 0, 8'h00, 1, 0, 1, 5, 0, 0, 1},
            '{0, 0, 8'h00, 1, 0, 1, 2, 0, 0, 1},
            '{0, 0, 8'h00, 1, 0, 1, 9, 1, 1, 1},
            '{1, 0, 8'h00, 0, 0, 2, 0, 0, 0, 0},
            '{0, 1, 8'd195, 0, 0, 2, 195, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 2, 200, 1, 1, 1},
            '{0, 0, 8'h00, 1, 1, 2, 200, 1, 1, 1},
            '{0, 0, 8'h00, 0, 1, 2, 200, 0, 0, 1},
            '{0, 1, 8'd5, 0, 0, 2, 5, 0, 0, 1},
            '{0, 0, 8'h00, 1, 0, 2, 0, 1, 1, 1},
            '{0, 0, 8'h00, 1, 0, 2, 0, 1, 1, 1},
            '{1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0},
            '{0, 1, 8'hFF, 0, 0, 0, 'hFF, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 0, 0, 1, 1, 1},
            '{0, 1, 8'h10, 1, 1, 0, 'h10, 0, 0, 1},
            '{1, 1, 8'hAA, 1, 1, 0, 0, 0, 0, 0},
            '{0, 1, 8'd100, 0, 0, 3, 100, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 3, 0, 1, 1, 1},
            '{0, 1, 8'hF0, 1, 1, 3, 100, 0, 0, 1},
            '{0, 1, 8'hF0, 1, 1, 3, 100, 0, 0, 1},
            '{0, 1, 8'hFF, 0, 0, 0, 'hFF, 0, 0, 0},
            '{0, 0, 8'h00, 1, 1, 0, 0, 1, 1, 1},
            '{0, 1, 8'h37, 0, 0, 0, 'h37, 0, 0, 1}
        };
        for (int i = 0; i < 4; i++) begin
            mc[i] = 0; mov[i] = 0; mwr[i] = 0;
        end
        #3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("por_count[%0d]", i), int'(cnt[i]), 0);
            chk($sformatf("por_ovf[%0d]", i), int'(ovf[i]), 0);
            chk($sformatf("por_wrapped[%0d]", i), int'(wr[i]), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        foreach (tbl[k]) tick(tbl[k], 1'b1);
        // asynchronous reset mid-cycle with counting enabled
        en = 1'b1; dir = 1'b1; clr = 1'b0; load = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_count[%0d]", i), int'(cnt[i]), 0);
            chk($sformatf("async_ovf[%0d]", i), int'(ovf[i]), 0);
            chk($sformatf("async_wrapped[%0d]", i), int'(wr[i]), 0);
            mc[i] = 0; mov[i] = 0; mwr[i] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("held_count[%0d]", i), int'(cnt[i]), 0);
        rst = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            rv.clr = ($urandom_range(0, 24) == 0);
            rv.load = ($urandom_range(0, 9) == 0);
            rv.lv = ($urandom_range(0, 3) == 0) ? 8'(250 + $urandom_range(0, 5)) : 8'($urandom);
            rv.en = ($urandom_range(0, 3) != 0);
            rv.dir = $urandom_range(0, 1) == 1;
            rv.idx = 0; rv.cnt = 0; rv.tc = 0; rv.wr = 0; rv.ovf = 0;
            tick(rv, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
